serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one bit per clock.
// Two half-adder cells plus a registered carry form the full-adder slice.
// An add started at edge E0 finishes at edge E_WIDTH with a one-cycle
// done pulse. The earliest next start is at E_WIDTH+2.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  add request, sampled only in IDLE
//   a, b   operands, captured when start is accepted
//   cin    carry-in, captured when start is accepted
//   busy   high in ADD and DONE
//   done   one-cycle completion pulse
//   sum    result, held until the next completion
//   cout   carry-out of bit WIDTH-1, held with sum
//   ovf    two's-complement overflow, held with sum
//
// Optional feature, macro SERIAL_ADDER_OVF_EN:
//   defined   -> ovf = carry into MSB ^ carry out of MSB, registered with sum
//   undefined -> ovf is tied to 0
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Full-adder slice built from two half-adder cells
  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic bit_s, bit_c;
  logic last;

  assign ha0_s = a_sh[0] ^ b_sh[0];
  assign ha0_c = a_sh[0] & b_sh[0];
  assign ha1_s = ha0_s ^ carry;
  assign ha1_c = ha0_s & carry;
  assign bit_s = ha1_s;
  assign bit_c = ha0_c | ha1_c;

  assign last  = (cnt == CW'(WIDTH - 1));

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ADD;
            busy  <= 1'b1;
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        ADD: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {bit_s, res_sh[WIDTH-1:1]};
          carry  <= bit_c;
          cnt    <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            sum   <= {bit_s, res_sh[WIDTH-1:1]};
            cout  <= bit_c;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // While the MSB is being added, carry holds the carry into that bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == ADD && last) begin
      ovf <= carry ^ bit_c;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder.
// It drives a WIDTH=8 instance with a vector table and directed
// corner sequences. It also drives a WIDTH=4 instance through an
// exhaustive sweep with start held high.
// Expected results are queued when an add is started and popped at done.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf_def;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp8_t;

  exp8_t      q8[$];
  logic [4:0] q4[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ovf_exp(input logic d);
`ifdef SERIAL_ADDER_OVF_EN
    return d;
`else
    return 1'b0 & d;
`endif
  endfunction

  // Pulse start for one cycle; returns at the negedge after the accept edge
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input bit push, input exp8_t e);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    if (push) q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    check("busy_rise", 32'(busy8), 32'd1);
  endtask

  // Wait for done, then check the latency, the result and the busy/done fall
  task automatic wait_done8(input string tag, input int exp_lat);
    int    lat;
    exp8_t e;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done8) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (lat == 0) return;
    if (q8.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_unexpected_done: got done with empty queue", tag);
      return;
    end
    e = q8.pop_front();
    check({tag, "_sum"},  32'(sum8),  32'(e.sum));
    check({tag, "_cout"}, 32'(cout8), 32'(e.cout));
    check({tag, "_ovf"},  32'(ovf8),  32'(e.ovf));
    check({tag, "_busy_at_done"}, 32'(busy8), 32'd1);
    @(negedge clk);
    check({tag, "_done_fall"}, 32'(done8), 32'd0);
    check({tag, "_busy_fall"}, 32'(busy8), 32'd0);
    check({tag, "_sum_hold"},  32'(sum8),  32'(e.sum));
  endtask

  // Watch for a stray done pulse over n cycles
  task automatic no_done8(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  vec_t  vt[8];
  exp8_t e;

  initial begin
    vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[6] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};
    vt[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum",  32'(sum8),  32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    check("rst_ovf",  32'(ovf8),  32'd0);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      e = '{vt[i].sum, vt[i].cout, ovf_exp(vt[i].ovf_def)};
      drive8(vt[i].a, vt[i].b, vt[i].cin, 1'b1, e);
      wait_done8($sformatf("vec%0d", i), 8);
    end

    // Second start and operand changes during ADD are ignored
    e = '{8'h46, 1'b0, 1'b0};
    drive8(8'h12, 8'h34, 1'b0, 1'b1, e);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    wait_done8("ignore_start", 5);
    no_done8("ignore_start_extra_done", 14);

    // Reset in the middle of an add aborts it
    e = '{8'h00, 1'b0, 1'b0};
    drive8(8'h55, 8'h0F, 1'b0, 1'b0, e);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_sum",  32'(sum8),  32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    no_done8("midrst_no_done", 12);
    e = '{8'h64, 1'b0, ovf_exp(1'b0)};
    drive8(8'h3C, 8'h28, 1'b0, 1'b1, e);
    wait_done8("after_rst", 8);

    // Reset wins over start on the same edge
    @(negedge clk);
    rst_n = 1'b0; start8 = 1'b1;
    @(negedge clk);
    check("rst_start_busy", 32'(busy8), 32'd0);
    rst_n = 1'b1; start8 = 1'b0;
    no_done8("rst_start_no_done", 12);

    // WIDTH=4 exhaustive sweep with start held high
    begin
      int         last_cyc;
      int         cyc;
      bit         seen;
      logic [8:0] kv;
      logic [4:0] ex;
      cyc = 0;
      last_cyc = 0;
      @(negedge clk);
      kv = 9'd0;
      a4 = kv[8:5]; b4 = kv[4:1]; cin4 = kv[0]; start4 = 1'b1;
      q4.push_back(5'(a4) + 5'(b4) + 5'(cin4));
      for (int k = 0; k < 512; k++) begin
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          cyc++;
          if (done4) begin
            seen = 1'b1;
            break;
          end
        end
        check("w4_done_seen", 32'(seen), 32'd1);
        if (!seen) break;
        ex = (q4.size() != 0) ? q4.pop_front() : 5'h1F;
        check($sformatf("w4_case%0d", k), 32'({cout4, sum4}), 32'(ex));
        if (k > 0) check("w4_spacing", 32'(cyc - last_cyc), 32'd6);
        last_cyc = cyc;
        if (k < 511) begin
          kv = 9'(k + 1);
          a4 = kv[8:5]; b4 = kv[4:1]; cin4 = kv[0];
          q4.push_back(5'(a4) + 5'(b4) + 5'(cin4));
        end else begin
          start4 = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
